// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-look-ahead adder/subtractor. The operands are split into
//   GROUP-bit slices, and each pipeline stage resolves one slice with a
//   flattened two-level lookahead. The slice carry is registered into the next
//   stage. Each stage keeps only the operand bits that later stages still need,
//   and the sum bits already computed ride along with the beat.
//
//   Latency is STAGES cycles and throughput is one beat per cycle. If the
//   output is valid but not taken, the whole pipeline holds.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle
//   a, b       operands (WIDTH bits)
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result (modulo 2^WIDTH)
//   cout       carry out of MSB (sub: 1 = no borrow)
//   ovf        signed two's-complement overflow

module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / GROUP;

    // One GROUP-bit lookahead slice. Each carry is written as a sum of
    // products over the slice generate/propagate terms, so carries do not
    // ripple through one another. Result is {carry_out, slice_sum}.
    function automatic logic [GROUP:0] cla_slice(
        input logic [GROUP-1:0] x,
        input logic [GROUP-1:0] y,
        input logic             ci
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             prod;
        logic             term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            term = 1'b0;
            prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                term = term | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = term | (prod & ci);
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic             stall;
    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Subtraction is a + ~b + ~cin.
    assign b_eff    = b ^ {WIDTH{sub}};
    assign c0       = cin ^ sub;

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unprocessed when the beat reaches this stage.
        localparam int REM = WIDTH - k * GROUP;

        logic [REM-1:0]   a_in;
        logic [REM-1:0]   b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [GROUP:0]   res;
        logic [WIDTH-1:0] s_nx;

        logic             v_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;

        if (k == 0) begin : g_src
            assign a_in = a;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = c0;
            assign v_in = in_valid;
        end else begin : g_src
            assign a_in = g_stage[k-1].g_fwd.a_q;
            assign b_in = g_stage[k-1].g_fwd.b_q;
            assign s_in = g_stage[k-1].s_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
        end

        assign res = cla_slice(a_in[GROUP-1:0], b_in[GROUP-1:0], c_in);

        always_comb begin
            s_nx = s_in;
            s_nx[k*GROUP +: GROUP] = res[GROUP-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (en) begin
                v_q <= v_in;
                s_q <= s_nx;
                c_q <= res[GROUP];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Upper operand bits travel on, shifted down so that the next
            // stage always takes its slice from the low GROUP bits.
            logic [REM-GROUP-1:0] a_q;
            logic [REM-GROUP-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[REM-1:GROUP];
                    b_q <= b_in[REM-1:GROUP];
                end
            end
        end else begin : g_ovf
            // The last stage holds the operand MSBs, so overflow is settled here.
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= (a_in[GROUP-1] == b_in[GROUP-1]) &&
                             (res[GROUP-1] != a_in[GROUP-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    localparam int W   = 16;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
        int           acc_stall;
    } exp_t;

    exp_t q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;
    bit   acc_flag  = 1'b0;
    bit   rnd_done  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic tc, input logic ts);
        exp_t e;
        int   r;
        int   sv;
        int   sa;
        int   sb;
        sa = int'($signed(ta));
        sb = int'($signed(tb_));
        if (!ts) begin
            r      = int'(ta) + int'(tb_) + int'(tc);
            sv     = sa + sb + int'(tc);
            e.cout = (r >= 65536);
        end else begin
            r      = int'(ta) - int'(tb_) - int'(tc);
            sv     = sa - sb - int'(tc);
            e.cout = (r >= 0);
        end
        e.sum       = W'(r & 32'hFFFF);
        e.ovf       = (sv > 32767) || (sv < -32768);
        e.acc_cyc   = 0;
        e.acc_stall = 0;
        return e;
    endfunction

    // Monitor and acceptance sampler, run away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        acc_flag = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = q[0];
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    if (!out_ready) begin
                        check("in_ready_stall", 32'(in_ready), 32'd0);
                        stall_cnt++;
                    end else begin
                        check("latency", 32'(cyc - e.acc_cyc), 32'(LAT + stall_cnt - e.acc_stall));
                        void'(q.pop_front());
                    end
                end
            end else begin
                check("in_ready_idle", 32'(in_ready), 32'd1);
            end
            if (in_valid && in_ready) begin
                e           = model(a, b, cin, sub);
                e.acc_cyc   = cyc;
                e.acc_stall = stall_cnt;
                q.push_back(e);
                acc_flag = 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts);
        bit got;
        got      = 1'b0;
        a        = ta;
        b        = tb_;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(posedge clk);
            if (acc_flag) got = 1'b1;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed boundary beats, back to back
        send(16'h0000, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0003, 16'h0005, 1'b1, 1'b1);
        send(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        send(16'h0000, 16'h0000, 1'b1, 1'b1);
        drain();

        // 8 back-to-back beats with a 3-cycle output stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand();
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random gaps on both sides
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'hAAAA, 16'h5555, 1'b1, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_quiet", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h4000, 16'h4000, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
